// File: rtl/mac_half_result_queue.sv
// mac_half_result_queue: tracks fp16 MAC results in flight and queues them,
// optionally ReLU-filtered, in a first-word-fall-through result FIFO.
module mac_half_result_queue #(
    parameter int LATENCY = 9,
    parameter int DEPTH   = 16,
    parameter int RELU_EN = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [15:0]              mac_q,
    output logic                     ovalid,
    input  logic                     iready,
    output logic [15:0]              dataout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(LATENCY + 1);

    // Negative values clamp to +0; NaNs keep their payload whatever the sign.
    function automatic logic [15:0] relu_f16(input logic [15:0] x);
        logic is_nan;
        is_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
        if (x[15] && !is_nan) begin
            relu_f16 = 16'h0000;
        end else begin
            relu_f16 = x;
        end
    endfunction

    logic [LATENCY-1:0] vld_sr_r;
    logic [IW-1:0]      inflight_r;
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [15:0]        mem_r [DEPTH];

    logic               issue_s;
    logic               push_s;
    logic               push_ok_s;
    logic               pop_s;
    logic               ovalid_s;
    logic [15:0]        wdata_s;

    // Handshake decode; credit check uses registered occupancy only.
    always_comb begin
        ovalid_s  = (count_r != CW'(0));
        oready    = ~reset & ((32'(count_r) + 32'(inflight_r)) < 32'(DEPTH));
        issue_s   = ivalid & oready;
        push_s    = vld_sr_r[LATENCY-1];
        push_ok_s = push_s & (count_r != CW'(DEPTH));
        pop_s     = ovalid_s & iready;
    end

    // Write-data filter.
    always_comb begin
        if (RELU_EN != 0) begin
            wdata_s = relu_f16(mac_q);
        end else begin
            wdata_s = mac_q;
        end
    end

    // Issue-tracking shift register and in-flight counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_sr_r   <= '0;
            inflight_r <= '0;
        end else begin
            vld_sr_r <= (vld_sr_r << 1) | LATENCY'(issue_s);
            case ({issue_s, push_s})
                2'b10:   inflight_r <= inflight_r + IW'(1);
                2'b01:   inflight_r <= inflight_r - IW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; left unreset because dataout is gated by occupancy.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // Output decode from registered state.
    always_comb begin
        ovalid = ovalid_s;
        count  = count_r;
        if (ovalid_s) begin
            dataout = mem_r[rd_ptr_r];
        end else begin
            dataout = 16'h0000;
        end
    end

endmodule

// File: tb/tb_mac_half_result_queue.sv
// Directed bench for mac_half_result_queue: a behavioural MAC delay line feeds
// two instances (ReLU on / off) and a scoreboard checks every popped result.
module tb_mac_half_result_queue;

    localparam int LAT = 9;
    localparam int DEP = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        ivalid;
    logic        iready;
    logic [15:0] mac_q;
    logic        oready, oready_raw;
    logic        ovalid, ovalid_raw;
    logic [15:0] dataout, dataout_raw;
    logic [4:0]  count, count_raw;

    always #5 clock = ~clock;

    mac_half_result_queue #(.LATENCY(LAT), .DEPTH(DEP), .RELU_EN(1)) u_dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready),
        .mac_q(mac_q), .ovalid(ovalid), .iready(iready), .dataout(dataout),
        .count(count)
    );

    mac_half_result_queue #(.LATENCY(LAT), .DEPTH(DEP), .RELU_EN(0)) u_raw (
        .clock(clock), .reset(reset), .ivalid(ivalid), .oready(oready_raw),
        .mac_q(mac_q), .ovalid(ovalid_raw), .iready(iready), .dataout(dataout_raw),
        .count(count_raw)
    );

    logic [15:0] pipe_d [LAT];
    logic [15:0] iss_data;
    logic [15:0] iss_exp;
    logic [15:0] sb_relu [$];
    logic [15:0] sb_raw  [$];
    int n_total = 0;
    int n_bad   = 0;
    int n_iss   = 0;
    int n_pop   = 0;
    int max_count = 0;

    assign mac_q = pipe_d[LAT-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // MAC model: the value issued at an edge appears on mac_q LAT cycles later.
    always @(posedge clock) begin
        pipe_d[0] <= (ivalid && oready) ? iss_data : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end

    // Scoreboard producer.
    always @(posedge clock) begin
        if (reset) begin
            sb_relu.delete();
            sb_raw.delete();
        end else if (ivalid && oready) begin
            sb_relu.push_back(iss_exp);
            sb_raw.push_back(iss_data);
            n_iss++;
        end
    end

    // Scoreboard consumer, sampled mid-cycle.
    always @(negedge clock) begin
        if (int'(count) > max_count) max_count = int'(count);
        if (ovalid && iready) begin
            check_val("pop_expected", 32'(sb_relu.size() != 0), 32'd1);
            if (sb_relu.size() != 0) begin
                check_val("dataout_relu", 32'(dataout), 32'(sb_relu.pop_front()));
                check_val("dataout_raw", 32'(dataout_raw), 32'(sb_raw.pop_front()));
                n_pop++;
            end
        end
    end

    logic [15:0] relu_in  [9] = '{16'hC000, 16'h8000, 16'hFC00, 16'h7E01, 16'hFE01,
                                  16'h0001, 16'h7C00, 16'h83FF, 16'hFC01};
    logic [15:0] relu_exp [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h7E01, 16'hFE01,
                                  16'h0001, 16'h7C00, 16'h0000, 16'hFC01};

    initial begin
        int base_iss;
        int base_pop;
        int bad_a;
        int bad_b;

        reset = 1'b1; ivalid = 1'b0; iready = 1'b0;
        iss_data = 16'h0000; iss_exp = 16'h0000;
        repeat (3) tick();
        check_val("rst_oready", 32'(oready), 32'd0);
        check_val("rst_ovalid", 32'(ovalid), 32'd0);
        check_val("rst_dataout", 32'(dataout), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        tick();
        check_val("post_rst_oready", 32'(oready), 32'd1);
        check_val("post_rst_ovalid", 32'(ovalid), 32'd0);

        // Single issue: result visible exactly one cycle after the push edge.
        iready = 1'b1; ivalid = 1'b1; iss_data = 16'h3C00; iss_exp = 16'h3C00;
        tick();
        ivalid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val("single_early_ovalid", 32'(ovalid), 32'd0);
        end
        tick();
        check_val("single_ovalid", 32'(ovalid), 32'd1);
        check_val("single_dataout", 32'(dataout), 32'h3C00);
        check_val("single_count", 32'(count), 32'd1);
        tick();
        check_val("single_popped", 32'(ovalid), 32'd0);

        // Backpressure: credits run out after 16 issues with 9 still in flight.
        iready = 1'b0; base_iss = n_iss; ivalid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            iss_data = 16'h1000 + 16'(n_iss); iss_exp = iss_data;
            tick();
        end
        check_val("bp_oready_15", 32'(oready), 32'd1);
        iss_data = 16'h1000 + 16'(n_iss); iss_exp = iss_data;
        tick();
        check_val("bp_oready_16", 32'(oready), 32'd0);
        check_val("bp_count_at_fall", 32'(count), 32'd7);
        for (int i = 0; i < 14; i++) begin
            iss_data = 16'h1000 + 16'(n_iss); iss_exp = iss_data;
            tick();
        end
        ivalid = 1'b0;
        check_val("bp_issued", 32'(n_iss - base_iss), 32'd16);
        check_val("bp_count_full", 32'(count), 32'd16);
        check_val("bp_max_count", 32'(max_count), 32'd16);
        check_val("bp_oready_full", 32'(oready), 32'd0);
        iready = 1'b1;
        repeat (20) tick();
        check_val("bp_drained", 32'(count), 32'd0);
        check_val("bp_sb_empty", 32'(sb_relu.size()), 32'd0);

        // ReLU filtering vs. bit-exact path.
        base_pop = n_pop;
        for (int i = 0; i < 9; i++) begin
            ivalid = 1'b1; iss_data = relu_in[i]; iss_exp = relu_exp[i];
            tick();
        end
        ivalid = 1'b0;
        repeat (12) tick();
        check_val("relu_pops", 32'(n_pop - base_pop), 32'd9);

        // Concurrent push/pop for 100 cycles.
        base_pop = n_pop; bad_a = 0; bad_b = 0; ivalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            iss_data = 16'h2000 + 16'(i); iss_exp = iss_data;
            tick();
            if (!oready) bad_a++;
            if (i >= 9 && count != 5'd1) bad_b++;
        end
        ivalid = 1'b0;
        repeat (15) tick();
        check_val("conc_oready_low", 32'(bad_a), 32'd0);
        check_val("conc_count_not1", 32'(bad_b), 32'd0);
        check_val("conc_pops", 32'(n_pop - base_pop), 32'd100);

        // Reset mid-flight drops everything, later MAC outputs are ignored.
        ivalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iss_data = 16'h3000 + 16'(i); iss_exp = iss_data;
            tick();
        end
        ivalid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        base_pop = n_pop; bad_a = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (count != 5'd0 || ovalid) bad_a++;
        end
        check_val("rmf_quiet", 32'(bad_a), 32'd0);
        check_val("rmf_no_pops", 32'(n_pop - base_pop), 32'd0);
        ivalid = 1'b1; iss_data = 16'h4444; iss_exp = 16'h4444;
        tick();
        ivalid = 1'b0;
        repeat (12) tick();
        check_val("rmf_new_pop", 32'(n_pop - base_pop), 32'd1);

        // Pointer wrap with random downstream stalls.
        base_iss = n_iss; base_pop = n_pop; ivalid = 1'b1;
        for (int g = 0; g < 400 && (n_iss - base_iss) < 40; g++) begin
            iss_data = 16'h0100 + 16'(n_iss); iss_exp = iss_data;
            iready = 1'($urandom_range(0, 1));
            tick();
        end
        ivalid = 1'b0;
        check_val("wrap_issued", 32'(n_iss - base_iss), 32'd40);
        iready = 1'b1;
        repeat (40) tick();
        check_val("wrap_pops", 32'(n_pop - base_pop), 32'd40);
        check_val("wrap_count", 32'(count), 32'd0);
        check_val("wrap_sb_empty", 32'(sb_relu.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_half_result_queue.md
MAC_HALF_RESULT_QUEUE -- requirements
Module: mac_half_result_queue

Interface
REQ-001 SHALL have parameter LATENCY, default 9, meaning MAC pipeline depth in cycles from operand issue to valid q.
REQ-002 SHALL have parameter DEPTH, default 16 (power of two, >= 2), meaning result FIFO entries.
REQ-003 SHALL have parameter RELU_EN, default 1, meaning fp16 ReLU applied on FIFO write when 1.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ivalid  in  1  upstream issues an operand triple to the MAC this cycle.
REQ-007 oready  out  1  upstream may issue; an issue counts only when ivalid & oready.
REQ-008 mac_q  in  16  fp16 result from MAC output, LATENCY cycles after issue.
REQ-009 ovalid  out  1  dataout holds a valid queued result.
REQ-010 iready  in  1  downstream accepts dataout this cycle.
REQ-011 dataout  out  16  FIFO head (fp16), first-word-fall-through.
REQ-012 count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Issue = ivalid & oready; issue SHALL enter a LATENCY-deep valid shift register; ivalid while oready=0 SHALL be dropped and not tracked.
REQ-014 Push SHALL occur in the cycle the shift register's last stage is 1, i.e. exactly LATENCY cycles after the issue edge, writing the (filtered) mac_q value.
REQ-015 Inflight counter SHALL equal the number of 1s in the shift register: +1 on issue, -1 on push, unchanged when both.
REQ-016 oready SHALL be 1 iff count + inflight < DEPTH, derived from registered state only (no combinational path from ivalid or iready).
REQ-017 Pop = ovalid & iready; head SHALL advance on the following edge.
REQ-018 ovalid SHALL be 1 iff count > 0; dataout SHALL be 16'h0000 when count = 0.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; push into empty FIFO SHALL appear at dataout the next cycle (no bypass).
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; FIFO overflow SHALL be impossible given REQ-016; push when count = DEPTH (unreachable) SHALL be discarded.
REQ-021 ReLU (RELU_EN=1): sign=1 and not NaN -> 16'h0000 (covers -0, negative normals/subnormals, -inf); NaN (exp=5'h1F, mant!=0) SHALL pass unchanged; sign=0 SHALL pass unchanged.
REQ-022 RELU_EN=0 SHALL store mac_q bit-exact.
REQ-023 Results SHALL leave in issue order; no reordering, no duplication.

Reset
REQ-024 reset=1 at a clock edge SHALL clear shift register, inflight, pointers, count.
REQ-025 During and after reset: ovalid=0, dataout=16'h0000, count=0; oready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight and queued results; MAC outputs arriving after reset SHALL not be pushed.

Verification
REQ-027 Single issue: ivalid pulse at cycle 0, mac_q=16'h3C00 at cycle 9 -> ovalid=1, dataout=16'h3C00 at cycle 10; iready=1 -> ovalid=0 at cycle 11.
REQ-028 Backpressure: iready=0, ivalid held 1 -> exactly 16 issues accepted, oready falls after 16th issue while 9 still in flight, count reaches 16, never 17.
REQ-029 ReLU: mac_q sequence C000, 8000, FC00, 7E01, FE01, 0001 -> dataout 0000, 0000, 0000, 7E01, FE01, 0001; with RELU_EN=0 all bit-exact.
REQ-030 Concurrent push/pop: continuous issue with iready=1 for 100 cycles -> count stays 1 in steady state, all 100 values in order, oready never 0.
REQ-031 Reset mid-flight: 5 issues, reset at cycle 4 for 1 cycle -> count=0, ovalid=0 through cycle 20 despite mac_q activity; new issue afterwards completes normally.
REQ-032 Wrap: 40 issues with random iready -> pointer wrap exercised, output order equals issue order, no loss.
